// File: rtl/sargantana_icache_flush_ctrl_if.sv
// Flush controller bundle: request/drain inputs from the front end,
// tag-clear strobes, stall and acks back out.
interface sargantana_icache_flush_ctrl_if #(
  parameter int ICACHE_DEPTH = 64,
  parameter int NUM_WAYS     = 4
);
  localparam int IDX_W = $clog2(ICACHE_DEPTH);

  logic                fencei_req_i;
  logic                ext_inval_req_i;
  logic                refill_busy_i;
  logic                tag_wr_en_o;
  logic [IDX_W-1:0]    tag_wr_idx_o;
  logic [NUM_WAYS-1:0] tag_wr_way_mask_o;
  logic                lookup_stall_o;
  logic                flush_busy_o;
  logic                fencei_ack_o;
  logic                ext_inval_ack_o;

  modport master (
    output fencei_req_i,
    output ext_inval_req_i,
    output refill_busy_i,
    input  tag_wr_en_o,
    input  tag_wr_idx_o,
    input  tag_wr_way_mask_o,
    input  lookup_stall_o,
    input  flush_busy_o,
    input  fencei_ack_o,
    input  ext_inval_ack_o
  );

  modport slave (
    input  fencei_req_i,
    input  ext_inval_req_i,
    input  refill_busy_i,
    output tag_wr_en_o,
    output tag_wr_idx_o,
    output tag_wr_way_mask_o,
    output lookup_stall_o,
    output flush_busy_o,
    output fencei_ack_o,
    output ext_inval_ack_o
  );
endinterface

// File: rtl/sargantana_icache_flush_ctrl.sv
// Icache flush sequencer: coalesces fence.i / external invalidates,
// drains refills, then clears every set of the tag array.
module sargantana_icache_flush_ctrl #(
  parameter int ICACHE_DEPTH = 64,
  parameter int NUM_WAYS     = 4
) (
  input logic clk_i,
  input logic rst_i,
  sargantana_icache_flush_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(ICACHE_DEPTH);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(ICACHE_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    WALK,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       served_q, served_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       req;
  logic             walk;
  logic             done;

  assign req = {bus.ext_inval_req_i, bus.fencei_req_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      served_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      served_q <= served_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q | req;
    served_d = served_q;
    idx_d    = idx_q;
    unique case (state_q)
      IDLE: begin
        if (pend_q != '0) state_d = DRAIN;
      end
      DRAIN: begin
        if (!bus.refill_busy_i) begin
          // Same-cycle requests stay pending for a later walk
          served_d = pend_q;
          pend_d   = req;
          idx_d    = '0;
          state_d  = WALK;
        end
      end
      WALK: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        served_d = '0;
        state_d  = (pend_q != '0) ? DRAIN : IDLE;
      end
    endcase
  end

  assign walk = (state_q == WALK);
  assign done = (state_q == DONE);

  assign bus.tag_wr_en_o       = walk;
  assign bus.tag_wr_idx_o      = walk ? idx_q : '0;
  assign bus.tag_wr_way_mask_o = {NUM_WAYS{walk}};
  assign bus.lookup_stall_o    = (state_q != IDLE);
  assign bus.flush_busy_o      = (state_q != IDLE);
  assign bus.fencei_ack_o      = done & served_q[0];
  assign bus.ext_inval_ack_o   = done & served_q[1];
endmodule

// File: tb/tb_sargantana_icache_flush_ctrl.sv
// Directed bench: DEPTH=64/4-way and DEPTH=2/1-way instances,
// cycle-exact checks of walk, acks, drain and reset.
module tb_sargantana_icache_flush_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sargantana_icache_flush_ctrl_if #(
    .ICACHE_DEPTH(64), .NUM_WAYS(4)
  ) fb ();
  sargantana_icache_flush_ctrl_if #(
    .ICACHE_DEPTH(2), .NUM_WAYS(1)
  ) fs ();

  sargantana_icache_flush_ctrl #(
    .ICACHE_DEPTH(64), .NUM_WAYS(4)
  ) u_big (
    .clk_i(clk), .rst_i(rst), .bus(fb.slave)
  );

  sargantana_icache_flush_ctrl #(
    .ICACHE_DEPTH(2), .NUM_WAYS(1)
  ) u_small (
    .clk_i(clk), .rst_i(rst), .bus(fs.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] obs_b();
    return {fb.tag_wr_en_o, fb.tag_wr_idx_o,
            fb.tag_wr_way_mask_o, fb.lookup_stall_o,
            fb.flush_busy_o, fb.fencei_ack_o,
            fb.ext_inval_ack_o};
  endfunction

  function automatic logic [14:0] mk_b(
    logic en, int idx, logic bsy,
    logic fa, logic ea);
    logic [5:0] i6;
    i6 = en ? 6'(idx) : 6'd0;
    return {en, i6, {4{en}}, bsy, bsy, fa, ea};
  endfunction

  function automatic logic [6:0] obs_s();
    return {fs.tag_wr_en_o, fs.tag_wr_idx_o,
            fs.tag_wr_way_mask_o, fs.lookup_stall_o,
            fs.flush_busy_o, fs.fencei_ack_o,
            fs.ext_inval_ack_o};
  endfunction

  function automatic logic [6:0] mk_s(
    logic en, int idx, logic bsy,
    logic fa, logic ea);
    logic i1;
    i1 = en ? idx[0] : 1'b0;
    return {en, i1, en, bsy, bsy, fa, ea};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    fb.fencei_req_i = 1'b1;
    fs.ext_inval_req_i = 1'b1;
    tick();
    tick();
    tests++;
    if (obs_b() !== 15'd0) begin
      fails++;
      $display("FAIL reset_big got=%h exp=0", obs_b());
    end
    tests++;
    if (obs_s() !== 7'd0) begin
      fails++;
      $display("FAIL reset_small got=%h exp=0", obs_s());
    end
    fb.fencei_req_i = 1'b0;
    fs.ext_inval_req_i = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  // fencei (and optionally ext) at cycle 0, refill idle
  task automatic test_walk(bit both);
    logic en;
    logic [14:0] e;
    fb.fencei_req_i = 1'b1;
    fb.ext_inval_req_i = both;
    tick();
    fb.fencei_req_i = 1'b0;
    fb.ext_inval_req_i = 1'b0;
    for (int c = 1; c <= 68; c++) begin
      en = (c >= 3 && c <= 66);
      e = mk_b(en, c - 3, c >= 2 && c <= 67,
               c == 67, both && c == 67);
      tests++;
      if (obs_b() !== e) begin
        fails++;
        $display("FAIL walk both=%0d cyc=%0d got=%h exp=%h",
                 both, c, obs_b(), e);
      end
      tick();
    end
  endtask

  task automatic test_refill_drain();
    logic en;
    logic [14:0] e;
    fb.fencei_req_i = 1'b1;
    fb.refill_busy_i = 1'b1;
    tick();
    fb.fencei_req_i = 1'b0;
    for (int c = 1; c <= 76; c++) begin
      en = (c >= 11 && c <= 74);
      e = mk_b(en, c - 11, c >= 2 && c <= 75,
               c == 75, 1'b0);
      tests++;
      if (obs_b() !== e) begin
        fails++;
        $display("FAIL drain cyc=%0d got=%h exp=%h",
                 c, obs_b(), e);
      end
      fb.refill_busy_i = (c < 10);
      tick();
    end
  endtask

  task automatic test_ext_during_walk();
    logic en1, en2;
    logic [14:0] e;
    fb.fencei_req_i = 1'b1;
    tick();
    fb.fencei_req_i = 1'b0;
    for (int c = 1; c <= 134; c++) begin
      en1 = (c >= 3 && c <= 66);
      en2 = (c >= 69 && c <= 132);
      e = mk_b(en1 | en2, en1 ? c - 3 : c - 69,
               c >= 2 && c <= 133, c == 67, c == 133);
      tests++;
      if (obs_b() !== e) begin
        fails++;
        $display("FAIL ext_in_walk cyc=%0d got=%h exp=%h",
                 c, obs_b(), e);
      end
      fb.ext_inval_req_i = (c == 23);
      tick();
    end
  endtask

  task automatic test_reset_mid_walk();
    logic en;
    logic [14:0] e;
    fb.fencei_req_i = 1'b1;
    tick();
    fb.fencei_req_i = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      en = (c >= 3 && c <= 33);
      e = mk_b(en, c - 3, c >= 2 && c <= 33,
               1'b0, 1'b0);
      tests++;
      if (obs_b() !== e) begin
        fails++;
        $display("FAIL rst_mid cyc=%0d got=%h exp=%h",
                 c, obs_b(), e);
      end
      rst = (c == 33);
      tick();
    end
    test_walk(1'b0);
  endtask

  // fencei, then ext in the DONE cycle: separate walk
  task automatic test_back_to_back();
    logic en;
    logic [6:0] e;
    fs.fencei_req_i = 1'b1;
    tick();
    fs.fencei_req_i = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      en = (c == 3 || c == 4 || c == 8 || c == 9);
      e = mk_s(en, (c == 4 || c == 9) ? 1 : 0,
               (c >= 2 && c <= 5) || (c >= 7 && c <= 10),
               c == 5, c == 10);
      tests++;
      if (obs_s() !== e) begin
        fails++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h",
                 c, obs_s(), e);
      end
      fs.ext_inval_req_i = (c == 5);
      tick();
    end
  endtask

  // ext arrives while DRAIN waits on refill: joins walk
  task automatic test_drain_join();
    logic en;
    logic [6:0] e;
    fs.fencei_req_i = 1'b1;
    fs.refill_busy_i = 1'b1;
    tick();
    fs.fencei_req_i = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      en = (c == 6 || c == 7);
      e = mk_s(en, c - 6, c >= 2 && c <= 8,
               c == 8, c == 8);
      tests++;
      if (obs_s() !== e) begin
        fails++;
        $display("FAIL join cyc=%0d got=%h exp=%h",
                 c, obs_s(), e);
      end
      fs.ext_inval_req_i = (c == 3);
      fs.refill_busy_i = (c < 5);
      tick();
    end
  endtask

  // ext in the capture cycle itself: kept for a later walk
  task automatic test_capture_edge();
    logic en;
    logic [6:0] e;
    fs.fencei_req_i = 1'b1;
    tick();
    fs.fencei_req_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      en = (c == 3 || c == 4 || c == 7 || c == 8);
      e = mk_s(en, (c == 4 || c == 8) ? 1 : 0,
               c >= 2 && c <= 9, c == 5, c == 9);
      tests++;
      if (obs_s() !== e) begin
        fails++;
        $display("FAIL capture cyc=%0d got=%h exp=%h",
                 c, obs_s(), e);
      end
      fs.ext_inval_req_i = (c == 2);
      tick();
    end
  endtask

  initial begin
    fb.fencei_req_i    = 1'b0;
    fb.ext_inval_req_i = 1'b0;
    fb.refill_busy_i   = 1'b0;
    fs.fencei_req_i    = 1'b0;
    fs.ext_inval_req_i = 1'b0;
    fs.refill_busy_i   = 1'b0;
    test_reset();
    test_walk(1'b0);
    test_walk(1'b1);
    test_refill_drain();
    test_ext_during_walk();
    test_reset_mid_walk();
    test_back_to_back();
    test_drain_join();
    test_capture_edge();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
